// File: rtl/prog_freq_divider.sv
// prog_freq_divider: a bank of NUM_CH runtime-programmable clock dividers on one clock.
// Each channel drives a registered divide-by-D level (high ceil(D/2), low floor(D/2)).
// A one-entry shadow slot holds a {ch, div, en} request until it can be applied
// without emitting a truncated or stretched period.
// Optional feature: define FREQ_DIV_STROBE_EN to add div_strobe, a one-cycle pulse
// coincident with every div_out rising edge.
module prog_freq_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] div_out
`ifdef FREQ_DIV_STROBE_EN
    ,
    output logic [NUM_CH-1:0] div_strobe
`endif
);

    // Config handshake: a transfer happens on a rising edge where cfg_valid and
    // cfg_ready are both 1. cfg_ready is simply "shadow slot empty", so it drops
    // for at least one cycle after every in-range transfer; the request fields
    // only need to be stable during the transfer cycle.

    // Per-channel running state
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [CNT_W-1:0]  r_div [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_out;

    // Shadow slot
    logic              r_pend;
    logic [CH_W-1:0]   r_sh_ch;
    logic [CNT_W-1:0]  r_sh_div;
    logic              r_sh_en;

    // Next-state values and decode
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_div_nxt [NUM_CH];
    logic [NUM_CH-1:0] w_en_nxt;
    logic [NUM_CH-1:0] w_out_nxt;
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] w_half;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_apply;
    logic              w_accept;
    logic              w_ch_ok;
    logic [CNT_W-1:0]  w_cfg_div;

    assign w_accept  = cfg_valid & ~r_pend;
    assign w_ch_ok   = (int'(cfg_ch) < NUM_CH);
    assign w_cfg_div = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;
    assign cfg_ready = ~r_pend;
    assign div_out   = r_out;

    // Boundary (last count of the period) and high-phase end (count ceil(D/2)-1,
    // written as floor((D-1)/2) so it cannot overflow at the maximum ratio).
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wrap[g] = r_en[g] && (r_cnt[g] == r_div[g] - CNT_W'(1));
        assign w_half[g] = (r_cnt[g] == ((r_div[g] - CNT_W'(1)) >> 1));
        assign w_sel[g]  = r_pend && (r_sh_ch == CH_W'(g));
    end

    // Per-channel next state: pending-entry application first, then free running.
    always_comb begin
        w_apply = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_div_nxt[i] = r_div[i];
            w_en_nxt[i]  = r_en[i];
            w_out_nxt[i] = r_out[i];
            if (w_sel[i] && !r_en[i]) begin
                // Stopped target: apply at once; start the first high phase if enabling.
                w_apply[i]   = 1'b1;
                w_div_nxt[i] = r_sh_div;
                if (r_sh_en) begin
                    w_en_nxt[i]  = 1'b1;
                    w_cnt_nxt[i] = '0;
                    w_out_nxt[i] = 1'b1;
                end
            end else if (w_sel[i] && !r_sh_en) begin
                // Running target being stopped: stop at once.
                w_apply[i]   = 1'b1;
                w_div_nxt[i] = r_sh_div;
                w_en_nxt[i]  = 1'b0;
                w_cnt_nxt[i] = '0;
                w_out_nxt[i] = 1'b0;
            end else if (w_sel[i] && (w_wrap[i] || sync_restart)) begin
                // Running target re-ratioed: swap in the new ratio at a period start.
                w_apply[i]   = 1'b1;
                w_div_nxt[i] = r_sh_div;
                w_cnt_nxt[i] = '0;
                w_out_nxt[i] = 1'b1;
            end else if (r_en[i]) begin
                if (sync_restart || w_wrap[i]) begin
                    w_cnt_nxt[i] = '0;
                    w_out_nxt[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    if (w_half[i]) begin
                        w_out_nxt[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Shadow slot: capture on transfer (out-of-range channels are dropped), clear on apply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend   <= 1'b0;
            r_sh_ch  <= '0;
            r_sh_div <= '0;
            r_sh_en  <= 1'b0;
        end else if (w_accept) begin
            r_pend   <= w_ch_ok;
            r_sh_ch  <= cfg_ch;
            r_sh_div <= w_cfg_div;
            r_sh_en  <= cfg_en;
        end else if (|w_apply) begin
            r_pend   <= 1'b0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
                r_div[i] <= CNT_W'(DEFAULT_DIV);
            end
            r_en  <= '0;
            r_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_div[i] <= w_div_nxt[i];
            end
            r_en  <= w_en_nxt;
            r_out <= w_out_nxt;
        end
    end

`ifdef FREQ_DIV_STROBE_EN
    // A period starts exactly when a running channel reloads count 0 with the output high.
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] r_strobe;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rise
        assign w_rise[g] = w_en_nxt[g] & w_out_nxt[g] & (w_cnt_nxt[g] == '0);
    end

    // Strobe register, aligned with the div_out rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_rise;
        end
    end

    assign div_strobe = r_strobe;
`endif

endmodule

// File: tb/tb_prog_freq_divider.sv
// Bench for prog_freq_divider: table of ratio vectors on stopped channels plus
// hand-written sequences for mid-period reconfiguration, sync_restart, out-of-range
// channel, strobe (when FREQ_DIV_STROBE_EN is defined) and asynchronous reset.
module tb_prog_freq_divider;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_valid3;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_en;
    logic       sync_restart;
    logic       cfg_ready;
    logic       cfg_ready3;
    logic [3:0] div_out;
    logic [2:0] div_out3;
`ifdef FREQ_DIV_STROBE_EN
    logic [3:0] div_strobe;
    logic [2:0] div_strobe3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] div;
        int         hi;
        int         lo;
    } vec_t;

    vec_t vecs [9];

    // Clock
    always #5 clk = ~clk;

    prog_freq_divider #(.NUM_CH(4), .CNT_W(8), .DEFAULT_DIV(2)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_en       (cfg_en),
        .sync_restart (sync_restart),
        .div_out      (div_out)
`ifdef FREQ_DIV_STROBE_EN
        ,
        .div_strobe   (div_strobe)
`endif
    );

    // Three-channel instance: channel code 3 is representable but out of range.
    prog_freq_divider #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(2)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid3),
        .cfg_ready    (cfg_ready3),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .cfg_en       (cfg_en),
        .sync_restart (sync_restart),
        .div_out      (div_out3)
`ifdef FREQ_DIV_STROBE_EN
        ,
        .div_strobe   (div_strobe3)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic do_cfg(input logic [1:0] ch, input logic [7:0] dv, input logic en);
        int w;
        w = 0;
        while (!cfg_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("cfg_ready_wait", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_en    = en;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] e_ch;
        logic [0:8] e_out3;
        logic [0:8] e_rdy3;
        logic [0:6] e_s0;
        logic [0:6] e_s2;
        int         per;

        vecs[0] = '{ch: 2'd0, div: 8'd2,   hi: 1,   lo: 1};
        vecs[1] = '{ch: 2'd1, div: 8'd5,   hi: 3,   lo: 2};
        vecs[2] = '{ch: 2'd2, div: 8'd3,   hi: 2,   lo: 1};
        vecs[3] = '{ch: 2'd3, div: 8'd0,   hi: 1,   lo: 1};
        vecs[4] = '{ch: 2'd0, div: 8'd1,   hi: 1,   lo: 1};
        vecs[5] = '{ch: 2'd1, div: 8'd4,   hi: 2,   lo: 2};
        vecs[6] = '{ch: 2'd2, div: 8'd7,   hi: 4,   lo: 3};
        vecs[7] = '{ch: 2'd3, div: 8'd255, hi: 128, lo: 127};
        vecs[8] = '{ch: 2'd1, div: 8'd6,   hi: 3,   lo: 3};

        reset        = 1'b1;
        cfg_valid    = 1'b0;
        cfg_valid3   = 1'b0;
        cfg_ch       = '0;
        cfg_div      = '0;
        cfg_en       = 1'b0;
        sync_restart = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_div_out", 32'(div_out), 32'h0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_div_out3", 32'(div_out3), 32'h0);
        check("rst_cfg_ready3", 32'(cfg_ready3), 32'd1);
`ifdef FREQ_DIV_STROBE_EN
        check("rst_strobe", 32'(div_strobe), 32'h0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Ratio table: enable on a stopped channel, watch two periods, stop again
        for (int v = 0; v < 9; v++) begin
            do_cfg(vecs[v].ch, vecs[v].div, 1'b1);
            check($sformatf("vec%0d_pending", v), 32'(cfg_ready), 32'd0);
            per = vecs[v].hi + vecs[v].lo;
            for (int k = 0; k < 2 * per; k++) begin
                @(negedge clk);
                e_ch = ((k % per) < vecs[v].hi) ? (4'b0001 << vecs[v].ch) : 4'b0000;
                check($sformatf("vec%0d_out_k%0d", v, k), 32'(div_out), 32'(e_ch));
            end
            check($sformatf("vec%0d_ready", v), 32'(cfg_ready), 32'd1);
            do_cfg(vecs[v].ch, 8'd2, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d_stop", v), 32'(div_out), 32'h0);
        end

        // Ratio change two cycles into a D=5 period: old period completes, then 2/1
        do_cfg(2'd1, 8'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        do_cfg(2'd1, 8'd3, 1'b1);
        e_out3 = 9'b100110110;
        e_rdy3 = 9'b000111111;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("rediv_out_k%0d", k), 32'(div_out[1]), 32'(e_out3[k]));
            check($sformatf("rediv_ready_k%0d", k), 32'(cfg_ready), 32'(e_rdy3[k]));
            @(negedge clk);
        end
        do_cfg(2'd1, 8'd2, 1'b0);
        @(negedge clk);
        check("rediv_stop", 32'(div_out), 32'h0);

        // sync_restart aligns ch0 (D=4) and ch2 (D=6)
        do_cfg(2'd0, 8'd4, 1'b1);
        @(negedge clk);
        do_cfg(2'd2, 8'd6, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("sync_before", 32'(div_out), 32'h4);
        sync_restart = 1'b1;
        @(negedge clk);
        sync_restart = 1'b0;
        e_s0 = 7'b1100110;
        e_s2 = 7'b1110001;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("sync_k%0d", k), 32'(div_out),
                  32'({1'b0, e_s2[k], 1'b0, e_s0[k]}));
            @(negedge clk);
        end
        do_cfg(2'd0, 8'd2, 1'b0);
        @(negedge clk);
        do_cfg(2'd2, 8'd2, 1'b0);
        @(negedge clk);
        check("sync_stop", 32'(div_out), 32'h0);

        // Out-of-range channel on the three-channel instance
        cfg_ch     = 2'd3;
        cfg_div    = 8'd5;
        cfg_en     = 1'b1;
        cfg_valid3 = 1'b1;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        check("oor_ready", 32'(cfg_ready3), 32'd1);
        check("oor_out", 32'(div_out3), 32'h0);
        repeat (3) @(negedge clk);
        check("oor_out_later", 32'(div_out3), 32'h0);
        cfg_ch     = 2'd2;
        cfg_div    = 8'd2;
        cfg_en     = 1'b1;
        cfg_valid3 = 1'b1;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        check("ch3_pending", 32'(cfg_ready3), 32'd0);
        @(negedge clk);
        check("ch3_rise", 32'(div_out3), 32'h4);
        check("ch3_ready", 32'(cfg_ready3), 32'd1);
        @(negedge clk);
        check("ch3_low", 32'(div_out3), 32'h0);
        @(negedge clk);
        check("ch3_rise2", 32'(div_out3), 32'h4);

`ifdef FREQ_DIV_STROBE_EN
        // Strobe: one cycle in four, on the rise; stops on disable
        do_cfg(2'd3, 8'd4, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("strobe_k%0d", k), 32'(div_strobe),
                  ((k % 4) == 0) ? 32'h8 : 32'h0);
        end
        do_cfg(2'd3, 8'd4, 1'b0);
        @(negedge clk);
        check("strobe_stop", 32'(div_strobe), 32'h0);
        check("strobe_stop_out", 32'(div_out), 32'h0);
`endif

        // Asynchronous reset mid-run with a pending entry
        do_cfg(2'd0, 8'd9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        do_cfg(2'd0, 8'd9, 1'b1);
        check("pre_rst_ready", 32'(cfg_ready), 32'd0);
        check("pre_rst_out", 32'(div_out), 32'h1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_out", 32'(div_out), 32'h0);
        check("async_rst_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle_k%0d", k), 32'(div_out), 32'h0);
        end
        check("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
